wb_burst_master: RTL and testbench

- Wishbone B3 initiator that drives the Wishbone slave port of the SDRAM controller.
- Turns a command descriptor into a single-beat (classic) cycle or an incrementing burst. Takes write beats from a data stream and returns read beats on an output stream.
- Used as the stimulus engine and as the bus master for on-chip SDRAM clients.

---
 rtl/wb_burst_master.sv | 175 +++++++++++++++++
 tb/tb_wb_burst_master.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_burst_master.sv
// wb_burst_master: Wishbone B3 initiator for the SDRAM controller slave port.
// Turns a command descriptor into a classic single-beat cycle or an
// incrementing burst. Write beats come from a valid/ready stream, and read
// beats leave on a pulse stream that has no backpressure.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a cycle when the
// slave does not ack within TIMEOUT strobe cycles. The abort is reported on err.
module wb_burst_master #(
  parameter int AW      = 26,
  parameter int DW      = 32,
  parameter int LENW    = 8,
  parameter int TIMEOUT = 255
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_i,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_we,
  input  logic [AW-1:0]   cmd_addr,
  input  logic [LENW-1:0] cmd_len,
  input  logic [DW/8-1:0] cmd_sel,
  input  logic [DW-1:0]   wr_data,
  input  logic            wr_valid,
  output logic            wr_ready,
  output logic [DW-1:0]   rd_data,
  output logic            rd_valid,
  output logic            done,
  output logic            err,
  output logic            busy,
  output logic            wb_cyc_o,
  output logic            wb_stb_o,
  output logic            wb_we_o,
  output logic [AW-1:0]   wb_addr_o,
  output logic [DW-1:0]   wb_dat_o,
  output logic [DW/8-1:0] wb_sel_o,
  output logic [2:0]      wb_cti_o,
  input  logic [DW-1:0]   wb_dat_i,
  input  logic            wb_ack_i
);

  localparam int SW = DW / 8;

  typedef enum logic {IDLE, BUS} state_t;

  state_t          state;
  logic [LENW-1:0] len_r;
  logic [LENW-1:0] cnt;
  logic            pending;
  logic            beat_ack;
  logic            last;
  logic            to_abort;

  // Cycle type for beat idx. A single-beat transfer stays classic.
  function automatic logic [2:0] cti_for(input logic [LENW-1:0] idx,
                                         input logic [LENW-1:0] len);
    if (len == '0)
      return 3'b000;
    else if (idx == len)
      return 3'b111;
    else
      return 3'b010;
  endfunction

  // A beat completes only when ack is seen while our strobe is high.
  assign beat_ack = wb_stb_o && wb_ack_i;
  assign last     = (cnt == len_r);

  assign cmd_ready = (state == IDLE) && !wb_rst_i;

  // Fetch a write beat when the data register is empty. Also fetch one when
  // the current non-last beat is being acked, so that stb can stay high.
  assign wr_ready = (state == BUS) && wb_we_o && !wb_rst_i &&
                    (!pending || (beat_ack && !last));

`ifdef WB_MASTER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);
  logic [TW-1:0] to_cnt;

  // Count strobe cycles that have no ack. The count restarts on every beat.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i)
      to_cnt <= '0;
    else if (wb_stb_o && !wb_ack_i && !to_abort)
      to_cnt <= to_cnt + TW'(1);
    else
      to_cnt <= '0;
  end

  assign to_abort = wb_stb_o && !wb_ack_i && (to_cnt == TW'(TIMEOUT - 1));
`else
  assign to_abort = 1'b0;
`endif

  // Main control FSM. It owns every registered bus and status output.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      len_r     <= '0;
      cnt       <= '0;
      pending   <= 1'b0;
      busy      <= 1'b0;
      wb_cyc_o  <= 1'b0;
      wb_stb_o  <= 1'b0;
      wb_we_o   <= 1'b0;
      wb_addr_o <= '0;
      wb_dat_o  <= '0;
      wb_sel_o  <= '0;
      wb_cti_o  <= 3'b000;
      rd_data   <= '0;
      rd_valid  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            state     <= BUS;
            busy      <= 1'b1;
            wb_cyc_o  <= 1'b1;
            wb_stb_o  <= !cmd_we;
            wb_we_o   <= cmd_we;
            wb_addr_o <= cmd_addr;
            wb_sel_o  <= cmd_sel;
            wb_cti_o  <= cti_for('0, cmd_len);
            len_r     <= cmd_len;
            cnt       <= '0;
            pending   <= 1'b0;
          end
        end
        BUS: begin
          if (to_abort) begin
            state    <= IDLE;
            busy     <= 1'b0;
            wb_cyc_o <= 1'b0;
            wb_stb_o <= 1'b0;
            pending  <= 1'b0;
            err      <= 1'b1;
          end else if (beat_ack) begin
            if (!wb_we_o) begin
              rd_data  <= wb_dat_i;
              rd_valid <= 1'b1;
            end
            if (last) begin
              state    <= IDLE;
              busy     <= 1'b0;
              wb_cyc_o <= 1'b0;
              wb_stb_o <= 1'b0;
              pending  <= 1'b0;
              done     <= 1'b1;
            end else begin
              wb_addr_o <= wb_addr_o + AW'(SW);
              cnt       <= cnt + LENW'(1);
              wb_cti_o  <= cti_for(cnt + LENW'(1), len_r);
              if (wb_we_o) begin
                if (wr_valid) begin
                  wb_dat_o <= wr_data;
                end else begin
                  wb_stb_o <= 1'b0;
                  pending  <= 1'b0;
                end
              end
            end
          end else if (wr_ready && wr_valid) begin
            wb_dat_o <= wr_data;
            pending  <= 1'b1;
            wb_stb_o <= 1'b1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// tb_wb_burst_master: directed bench for wb_burst_master.
// A behavioural Wishbone slave with a configurable ack delay works on the
// falling edge. It logs every completed beat. Write beats come from a queue
// that can be made to stall, and the output pulses are counted by monitors.
module tb_wb_burst_master;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_we = 1'b0;
  logic [25:0] cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [3:0]  cmd_sel = '0;
  logic [31:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic        wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid;
  logic        done;
  logic        err;
  logic        busy;
  logic        wb_cyc_o;
  logic        wb_stb_o;
  logic        wb_we_o;
  logic [25:0] wb_addr_o;
  logic [31:0] wb_dat_o;
  logic [3:0]  wb_sel_o;
  logic [2:0]  wb_cti_o;
  logic [31:0] wb_dat_i = '0;
  logic        wb_ack_i = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  int ackDelay = 0;
  bit noAck = 1'b0;
  int waitCnt = 0;
  int cycleNo = 0;
  int lastAckCycle = 0;
  int doneCycle = 0;
  logic cycAtDone = 1'b0;
  logic cycAtErr = 1'b0;
  logic busyAtErr = 1'b0;
  int doneCount = 0;
  int errCount = 0;
  int stbRises = 0;
  int stbHighCycles = 0;
  int waitCycles = 0;
  int wrHandshakes = 0;
  logic prevStb = 1'b0;

  logic [25:0] logAddr[$];
  logic [31:0] logData[$];
  logic [2:0]  logCti[$];
  logic [3:0]  logSel[$];
  logic        logWe[$];
  logic [31:0] rdQ[$];
  logic [31:0] wrQ[$];
  int wrIdx = 0;
  int stallAt = -1;
  int stallCnt = 0;

  wb_burst_master #(.AW(26), .DW(32), .LENW(8), .TIMEOUT(16)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_sel(cmd_sel),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done), .err(err), .busy(busy),
    .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o),
    .wb_addr_o(wb_addr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o),
    .wb_cti_o(wb_cti_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
  );

  always #5 clk = ~clk;

  // The slave memory returns an address-derived pattern on reads.
  function automatic logic [31:0] memVal(input logic [25:0] a);
    return 32'h5A00_0000 ^ {6'd0, a};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Slave, write-stream source and monitors all run on the falling edge.
  always @(negedge clk) begin
    bit stalling;
    cycleNo++;
    if (rst) begin
      wb_ack_i = 1'b0;
      waitCnt  = 0;
    end else if (wb_ack_i) begin
      wb_ack_i = 1'b0;
      waitCnt  = 0;
    end else if (wb_cyc_o && wb_stb_o && !noAck) begin
      if (waitCnt >= ackDelay) begin
        wb_ack_i = 1'b1;
        wb_dat_i = memVal(wb_addr_o);
        logAddr.push_back(wb_addr_o);
        logData.push_back(wb_we_o ? wb_dat_o : memVal(wb_addr_o));
        logCti.push_back(wb_cti_o);
        logSel.push_back(wb_sel_o);
        logWe.push_back(wb_we_o);
        lastAckCycle = cycleNo;
      end else begin
        waitCnt++;
      end
    end else begin
      waitCnt = 0;
    end

    if (rd_valid) rdQ.push_back(rd_data);
    if (done) begin
      doneCount++;
      doneCycle = cycleNo;
      cycAtDone = wb_cyc_o;
    end
    if (err) begin
      errCount++;
      cycAtErr  = wb_cyc_o;
      busyAtErr = busy;
    end
    if (wb_stb_o && !prevStb) stbRises++;
    prevStb = wb_stb_o;
    if (wb_stb_o) stbHighCycles++;
    if (wb_cyc_o && !wb_stb_o && wb_addr_o == 26'h208) waitCycles++;

    stalling = (wrIdx == stallAt) && (stallCnt > 0);
    wr_valid = (wrIdx < wrQ.size()) && !stalling;
    wr_data  = wr_valid ? wrQ[wrIdx] : 32'h0;
    #1;
    if (wr_ready && wr_valid) begin
      wrHandshakes++;
      wrIdx++;
    end
    if (stalling && wr_ready) stallCnt--;
  end

  task automatic clearLogs();
    logAddr.delete(); logData.delete(); logCti.delete();
    logSel.delete(); logWe.delete(); rdQ.delete(); wrQ.delete();
    wrIdx = 0; wrHandshakes = 0; stbRises = 0; stallAt = -1; stallCnt = 0;
  endtask

  task automatic applyStimulus(input logic we, input logic [25:0] addr,
                               input logic [7:0] len, input logic [3:0] sel);
    int tries;
    @(negedge clk); #2;
    cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_len = len; cmd_sel = sel;
    tries = 0;
    while (!cmd_ready && tries < 20) begin
      @(negedge clk); #2;
      tries++;
    end
    if (!cmd_ready) checkOutput("cmd_accept", 64'(cmd_ready), 64'h1);
    @(negedge clk); #2;
    cmd_valid = 1'b0;
  endtask

  task automatic waitDone(input int budget);
    int start;
    int n;
    start = doneCount;
    n = 0;
    while (doneCount == start && n < budget) begin
      @(negedge clk); #2;
      n++;
    end
    if (doneCount == start) checkOutput("done_timeout", 64'(doneCount), 64'(start + 1));
    @(negedge clk); #2;
  endtask

  initial begin
    int d0;
    int n;
    logic [25:0] a;

    // Reset state
    repeat (3) @(negedge clk);
    #2;
    checkOutput("rst_ctrl", {cmd_ready, wr_ready, wb_cyc_o, wb_stb_o, wb_we_o, busy, done, err, rd_valid}, 64'h0);
    checkOutput("rst_bus", {wb_addr_o, wb_dat_o, wb_sel_o, wb_cti_o}, 64'h0);
    checkOutput("rst_rddata", 64'(rd_data), 64'h0);
    rst = 1'b0;
    @(negedge clk); #2;
    checkOutput("idle_ready", {cmd_ready, busy}, 64'h2);

    // Single write: classic cycle, one strobe
    clearLogs(); ackDelay = 3;
    wrQ.push_back(32'hDEAD_BEEF);
    d0 = doneCount;
    applyStimulus(1'b1, 26'h100, 8'd0, 4'hF);
    waitDone(60);
    checkOutput("t1_beats", 64'(logAddr.size()), 64'd1);
    checkOutput("t1_addr", 64'(logAddr[0]), 64'h100);
    checkOutput("t1_data", 64'(logData[0]), 64'hDEAD_BEEF);
    checkOutput("t1_cti", 64'(logCti[0]), 64'h0);
    checkOutput("t1_sel_we", {logSel[0], logWe[0]}, {4'hF, 1'b1});
    checkOutput("t1_stb_rises", 64'(stbRises), 64'd1);
    checkOutput("t1_done_cnt", 64'(doneCount - d0), 64'd1);
    checkOutput("t1_done_lat", 64'(doneCycle - lastAckCycle), 64'd1);
    checkOutput("t1_cyc_at_done", 64'(cycAtDone), 64'h0);

    // Write burst of four beats
    clearLogs(); ackDelay = 1;
    wrQ.push_back(32'h11); wrQ.push_back(32'h22); wrQ.push_back(32'h33); wrQ.push_back(32'h44);
    d0 = doneCount;
    applyStimulus(1'b1, 26'h200, 8'd3, 4'hF);
    waitDone(100);
    checkOutput("t2_beats", 64'(logAddr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t2_addr%0d", i), 64'(logAddr[i]), 64'(26'h200 + 26'(4 * i)));
      checkOutput($sformatf("t2_data%0d", i), 64'(logData[i]), 64'(32'h11 * (i + 1)));
      checkOutput($sformatf("t2_cti%0d", i), 64'(logCti[i]), (i == 3) ? 64'h7 : 64'h2);
    end
    checkOutput("t2_wr_hs", 64'(wrHandshakes), 64'd4);
    checkOutput("t2_done_cnt", 64'(doneCount - d0), 64'd1);

    // Read burst of eight beats that wraps the address space
    clearLogs(); ackDelay = 0;
    d0 = doneCount;
    applyStimulus(1'b0, 26'h3FF_FFF8, 8'd7, 4'hF);
    waitDone(100);
    checkOutput("t3_beats", 64'(logAddr.size()), 64'd8);
    checkOutput("t3_rd_cnt", 64'(rdQ.size()), 64'd8);
    for (int i = 0; i < 8; i++) begin
      a = 26'h3FF_FFF8 + 26'(4 * i);
      checkOutput($sformatf("t3_addr%0d", i), 64'(logAddr[i]), 64'(a));
      checkOutput($sformatf("t3_rd%0d", i), 64'(rdQ[i]), 64'(memVal(a)));
    end
    checkOutput("t3_addr2_wrap", 64'(logAddr[2]), 64'h0);
    checkOutput("t3_cti_last", 64'(logCti[7]), 64'h7);
    checkOutput("t3_done_lat", 64'(doneCycle - lastAckCycle), 64'd1);
    checkOutput("t3_done_cnt", 64'(doneCount - d0), 64'd1);

    // Write burst where the source stalls before beat 2
    clearLogs(); ackDelay = 0; waitCycles = 0;
    wrQ.push_back(32'hA1); wrQ.push_back(32'hA2); wrQ.push_back(32'hA3); wrQ.push_back(32'hA4);
    stallAt = 2; stallCnt = 5;
    d0 = doneCount;
    applyStimulus(1'b1, 26'h200, 8'd3, 4'h3);
    waitDone(100);
    checkOutput("t4_wait_cycles", 64'(waitCycles), 64'd5);
    checkOutput("t4_beats", 64'(logAddr.size()), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t4_addr%0d", i), 64'(logAddr[i]), 64'(26'h200 + 26'(4 * i)));
      checkOutput($sformatf("t4_data%0d", i), 64'(logData[i]), 64'(32'hA1 + i));
    end
    checkOutput("t4_sel", 64'(logSel[3]), 64'h3);
    checkOutput("t4_done_cnt", 64'(doneCount - d0), 64'd1);

    // Reset pulse during beat 2 of a read burst
    clearLogs(); ackDelay = 2;
    d0 = doneCount;
    applyStimulus(1'b0, 26'h1000, 8'd3, 4'hF);
    n = 0;
    while (logAddr.size() < 2 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    checkOutput("t5_two_beats", 64'(logAddr.size()), 64'd2);
    @(negedge clk); #2;
    rst = 1'b1;
    @(negedge clk); #2;
    rst = 1'b0;
    checkOutput("t5_bus_idle", {wb_cyc_o, wb_stb_o, busy}, 64'h0);
    repeat (8) @(negedge clk);
    #2;
    checkOutput("t5_no_done", 64'(doneCount - d0), 64'd0);
    checkOutput("t5_rd_cnt", 64'(rdQ.size()), 64'd2);
    checkOutput("t5_no_more_beats", 64'(logAddr.size()), 64'd2);
    ackDelay = 0;
    applyStimulus(1'b0, 26'h40, 8'd0, 4'hF);
    waitDone(60);
    checkOutput("t5_new_done", 64'(doneCount - d0), 64'd1);
    checkOutput("t5_new_rd", 64'(rdQ[2]), 64'(memVal(26'h40)));
    checkOutput("t5_new_cti", 64'(logCti[2]), 64'h0);

`ifdef WB_MASTER_TIMEOUT_EN
    // Slave never acks, so the master must give up after 16 strobe cycles
    clearLogs(); noAck = 1'b1; stbHighCycles = 0;
    d0 = doneCount;
    applyStimulus(1'b0, 26'h80, 8'd0, 4'hF);
    n = 0;
    while (errCount == 0 && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    checkOutput("t6_err_cnt", 64'(errCount), 64'd1);
    checkOutput("t6_stb_cycles", 64'(stbHighCycles), 64'd16);
    checkOutput("t6_cyc_busy_at_err", {cycAtErr, busyAtErr}, 64'h0);
    repeat (4) @(negedge clk);
    #2;
    checkOutput("t6_no_done", 64'(doneCount - d0), 64'd0);
    checkOutput("t6_idle", {wb_cyc_o, wb_stb_o, busy, cmd_ready}, 64'h1);
    noAck = 1'b0;
`else
    checkOutput("err_never", 64'(errCount), 64'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Overall time limit: a hang is reported as a failure.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
